// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: one outstanding word read per req/ack handshake.
// Buses are [0:31] with bit 0 as the MSB.
interface fetch_unit_if;
   logic        imem_req;
   logic [0:31] imem_addr;
   logic        imem_ack;
   logic [0:31] imem_rdata;

   // Fetch side issues requests; memory side acknowledges with data.
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, one-at-a-time memory reads and a two-entry
// buffer (output register plus skid register) in front of decode. A redirect flushes the
// buffer and restarts fetch at a new word-aligned address.
module fetch_unit #(
   parameter logic [0:31] RESET_PC = 32'h0000_0000,
   parameter logic [0:31] NOP_INSN = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         stall,
   input  logic         redirect,
   input  logic [0:31]  redirect_pc,
   fetch_unit_if.master imem,
   output logic [0:31]  insn,
   output logic [0:31]  pc,
   output logic         insn_valid
);

   logic [0:31] fetch_pc_q, fetch_pc_d;
   logic [0:31] out_insn_q, out_insn_d;
   logic [0:31] out_pc_q, out_pc_d;
   logic        out_valid_q, out_valid_d;
   logic [0:31] skid_insn_q, skid_insn_d;
   logic [0:31] skid_pc_q, skid_pc_d;
   logic        skid_valid_q, skid_valid_d;
   logic        accept;
   logic        fill;
   logic        unused_redirect_lsbs;

   // Byte offset of a redirect target is dropped; fetch is always word aligned.
   assign unused_redirect_lsbs = ^redirect_pc[30:31];

   // A full skid means no room for another word, so stop requesting.
   assign imem.imem_req  = reset_n & ~skid_valid_q & ~redirect;
   assign imem.imem_addr = fetch_pc_q;

   assign accept = out_valid_q & ~stall;
   assign fill   = imem.imem_req & imem.imem_ack;

   assign insn       = out_insn_q;
   assign pc         = out_pc_q;
   assign insn_valid = out_valid_q;

   // Next-state: redirect flush, else fill from memory, else drain/consume.
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      out_insn_d   = out_insn_q;
      out_pc_d     = out_pc_q;
      out_valid_d  = out_valid_q;
      skid_insn_d  = skid_insn_q;
      skid_pc_d    = skid_pc_q;
      skid_valid_d = skid_valid_q;

      if (redirect) begin
         fetch_pc_d   = {redirect_pc[0:29], 2'b00};
         out_insn_d   = NOP_INSN;
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (fill) begin
         // fill implies the skid is empty (req is gated by skid_valid_q)
         fetch_pc_d = fetch_pc_q + 32'd4;
         if (!out_valid_q || accept) begin
            out_insn_d  = imem.imem_rdata;
            out_pc_d    = fetch_pc_q;
            out_valid_d = 1'b1;
         end else begin
            skid_insn_d  = imem.imem_rdata;
            skid_pc_d    = fetch_pc_q;
            skid_valid_d = 1'b1;
         end
      end else if (accept) begin
         if (skid_valid_q) begin
            out_insn_d   = skid_insn_q;
            out_pc_d     = skid_pc_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_insn_d  = NOP_INSN;
            out_valid_d = 1'b0;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_pc_q   <= RESET_PC;
         out_insn_q   <= NOP_INSN;
         out_pc_q     <= RESET_PC;
         out_valid_q  <= 1'b0;
         skid_insn_q  <= NOP_INSN;
         skid_pc_q    <= RESET_PC;
         skid_valid_q <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         out_insn_q   <= out_insn_d;
         out_pc_q     <= out_pc_d;
         out_valid_q  <= out_valid_d;
         skid_insn_q  <= skid_insn_d;
         skid_pc_q    <= skid_pc_d;
         skid_valid_q <= skid_valid_d;
      end
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the decode stage. Holds the program counter, issues one word read per request to instruction memory over a req/ack handshake, and presents each returned instruction with its address (`insn`, `pc`, `insn_valid`). A two-entry buffer (output register plus skid register) absorbs one returned word while decode is stalled. Redirect input from branch/jump resolution flushes the buffer and restarts fetch at a new address.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSN`, default 32'h0000_0000: value driven on `insn` when no instruction is valid.

All 32-bit buses are declared [0:31]: bit 0 is the MSB, so opcode = insn[0:5] and byte offset = addr[30:31].

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `stall`  in  1  decode cannot accept; output register must hold.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  [0:31]  new fetch address; bits [30:31] ignored (treated as 0).
- `imem_req`  out  1  read request.
- `imem_addr`  out  [0:31]  word address of the request; bits [30:31] always 0.
- `imem_ack`  in  1  read complete this cycle; meaningful only while `imem_req`=1.
- `imem_rdata`  in  [0:31]  instruction for the `imem_addr` presented in the ack cycle.
- `insn`  out  [0:31]  instruction to decode.
- `pc`  out  [0:31]  address of `insn`.
- `insn_valid`  out  1  `insn`/`pc` valid.

## Operation
- State: `fetch_pc` [0:31], output register {insn, pc, valid}, skid register {insn, pc, valid}.
- Reset (`reset_n`=0 at an edge): `fetch_pc`=RESET_PC, both valids=0, `insn`=NOP_INSN, `pc`=RESET_PC. During reset `imem_req`=0.
- `imem_req` = reset_n & !skid.valid & !redirect. `imem_addr` = `fetch_pc`, with no other gating (combinational).
- Accept: the output is consumed in a cycle where insn_valid=1 and stall=0.
- Fill, i.e. an ack cycle with `imem_req`=1, `imem_ack`=1, `redirect`=0:
  - If the output is empty or consumed this cycle, and the skid is empty: the word goes to the output register as {imem_rdata, fetch_pc}.
  - Else (output full and stalled): the word goes to the skid register.
  - `fetch_pc` += 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Drain: if the output is consumed and the skid is valid, the skid moves to the output and skid.valid clears. An ack cannot coincide with this, because `imem_req`=0 while the skid is full.
- Consumed with no refill: `insn_valid`=0 and `insn`=NOP_INSN.
- Redirect: `redirect`=1 overrides `stall` and any same-cycle ack. The returned word is discarded, both valids clear, `insn`=NOP_INSN, and `fetch_pc`=redirect_pc with bits [30:31]=0.
- Priority: reset > redirect > fill/drain.
- The memory may ack any number of cycles after `imem_req` rises, including the same cycle. Only one transaction is outstanding at a time, and it is always for the currently presented `imem_addr`.

## Timing
- Ack in cycle N → `insn_valid`=1 with that word on `insn` in cycle N+1. With the memory acking every cycle and `stall`=0, throughput is 1 insn/cycle.
- Stall raised while acks continue → at most one further word is accepted (into the skid). `imem_req` drops the cycle after the skid fills.
- Stall released in cycle M → skid word on the output in M+1, and `imem_req` reasserts in M+1.
- Redirect in cycle N → `insn_valid`=0 in N+1, `imem_addr`=redirect target in N+1. First valid redirected instruction appears in N+2 at the earliest.
- Reset release: first cycle with `reset_n`=1 drives `imem_req`=1 and `imem_addr`=RESET_PC.
- Outputs never change while `insn_valid`=1 and `stall`=1, unless `redirect` or reset occurs.

## Test plan
- Reset, then memory acking every cycle, stall=0 → `pc` sequence 0, 4, 8, 12 on consecutive cycles starting 2 cycles after release, with `insn` matching memory contents.
- stall=1 for 5 cycles during streaming → output frozen, exactly one extra word held, `imem_req`=0 from the 2nd stall cycle. On release, the held word appears next cycle, no word is lost or duplicated, and the `pc` order is preserved.
- redirect=1 with redirect_pc=32'h0000_0103 in the same cycle as an ack of addr 0x10 → the ack word is dropped, the next cycle has `imem_addr`=32'h0000_0100 and `insn_valid`=0, and the next valid `pc`=0x100.
- Redirect while output and skid are both full and stall=1 → both flushed, `insn`=NOP_INSN, fetch resumes at the target.
- Memory ack latency of 3 cycles → one instruction every 4 cycles, `imem_addr` held stable while waiting.
- `fetch_pc`=32'hFFFF_FFFC, ack → next `imem_addr`=32'h0000_0000. Separately, `reset_n`=0 mid-stream → all outputs reach their reset values at the next edge.
